sseg_scan_ctrl: RTL and testbench

//  Sequencer between the Babbage engine datapath and the 4-digit seven-segment display.
//  - Accepts a 13-bit binary result on a load pulse and converts it to 4 BCD digits by

---
 rtl/sseg_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: converts a 13-bit binary result into four BCD digits (shift-add-3, one bit
// per clock) and scans the held digits onto a 4-digit seven-segment display.
//
// Ports:
//   clk        - system clock, all state on rising edge
//   reset_n    - asynchronous active-low reset
//   load       - one-cycle request: capture bin_in and start a conversion
//   bin_in     - unsigned binary value 0..8191
//   busy       - conversion in progress
//   done_tick  - one-cycle pulse: new digits now held for display
//   digit_sel  - index of the digit currently scanned (0 = ones)
//   bcd_digit  - BCD value of the selected digit
//   an         - active-low anode enables (4'b1111 = all off)
module sseg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LEAD  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [12:0] bin_in,
  output logic        busy,
  output logic        done_tick,
  output logic [1:0]  digit_sel,
  output logic [3:0]  bcd_digit,
  output logic [3:0]  an
);

  typedef enum logic [1:0] {StIdle, StConv, StLatch} state_e;

  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(REFRESH_DIV - 1);

  state_e      state_q;
  logic [12:0] shreg_q;
  logic [15:0] acc_q;
  logic [3:0]  bit_cnt_q;
  logic [12:0] pend_q;
  logic        pend_valid_q;
  logic [15:0] disp_q;
  logic        done_q;

  logic [15:0] acc_adj;
  logic [28:0] shifted;

  // Add 3 to every nibble >= 5 before the shift so each digit carries correctly.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < 4; k++) begin
      if (acc_q[k*4 +: 4] >= 4'd5) acc_adj[k*4 +: 4] = acc_q[k*4 +: 4] + 4'd3;
    end
    shifted = {acc_adj, shreg_q} << 1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Requests arriving while busy are parked; latest one wins.
      if (load && (state_q != StIdle)) begin
        pend_q       <= bin_in;
        pend_valid_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (load) begin
            shreg_q   <= bin_in;
            acc_q     <= '0;
            bit_cnt_q <= 4'd12;
            state_q   <= StConv;
          end
        end
        StConv: begin
          acc_q   <= shifted[28:13];
          shreg_q <= shifted[12:0];
          if (bit_cnt_q == 4'd0) state_q <= StLatch;
          else                   bit_cnt_q <= bit_cnt_q - 4'd1;
        end
        StLatch: begin
          disp_q <= acc_q;
          done_q <= 1'b1;
          // A load on this very edge is the newest request, so it beats the parked one.
          if (load || pend_valid_q) begin
            shreg_q      <= load ? bin_in : pend_q;
            acc_q        <= '0;
            bit_cnt_q    <= 4'd12;
            pend_valid_q <= 1'b0;
            state_q      <= StConv;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Free-running digit scan, independent of conversion activity.
  logic [PreW-1:0] prescale_q, prescale_d;
  logic [1:0]      sel_q, sel_d;

  always_comb begin
    prescale_d = prescale_q + 1'b1;
    sel_d      = sel_q;
    if (prescale_q == PreMax) begin
      prescale_d = '0;
      sel_d      = sel_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= '0;
      sel_q      <= '0;
    end else begin
      prescale_q <= prescale_d;
      sel_q      <= sel_d;
    end
  end

  // Digit k (k>0) is blank when it and every more significant digit are zero.
  logic [3:0] blank;
  logic [3:0] sel_onehot;

  always_comb begin
    blank[3]   = BLANK_LEAD && (disp_q[15:12] == 4'd0);
    blank[2]   = blank[3] && (disp_q[11:8] == 4'd0);
    blank[1]   = blank[2] && (disp_q[7:4] == 4'd0);
    blank[0]   = 1'b0;
    sel_onehot = 4'b0001 << sel_q;
    bcd_digit  = disp_q[sel_q*4 +: 4];
    an         = blank[sel_q] ? 4'b1111 : ~sel_onehot;
  end

  assign busy      = (state_q != StIdle);
  assign done_tick = done_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [12:0] bin_in;

  logic       busy4, done4, busy1, done1;
  logic [1:0] sel4, sel1;
  logic [3:0] bcd4, bcd1, an4, an1;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cnt;

  always #5 clk = ~clk;

  // Cycles since reset release: predicts the prescaler/digit_sel phase.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= 0;
    else          cnt <= cnt + 1;
  end

  sseg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LEAD(1'b1)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .load(load), .bin_in(bin_in),
    .busy(busy4), .done_tick(done4), .digit_sel(sel4), .bcd_digit(bcd4), .an(an4)
  );

  sseg_scan_ctrl #(.REFRESH_DIV(1), .BLANK_LEAD(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .load(load), .bin_in(bin_in),
    .busy(busy1), .done_tick(done1), .digit_sel(sel1), .bcd_digit(bcd1), .an(an1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] an_exp(input logic [3:0] blank, input int s);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    return blank[s] ? 4'b1111 : ~oh;
  endfunction

  function automatic logic [3:0] dig(input logic [15:0] b, input int s);
    return b[s*4 +: 4];
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; load = 1'b0; bin_in = '0;
    step(); step();
    n_cmp++; if (an4 !== 4'b1110) begin n_err++; $display("FAIL reset_an got %b exp 1110", an4); end
    n_cmp++; if (bcd4 !== 4'd0) begin n_err++; $display("FAIL reset_bcd got %0d exp 0", bcd4); end
    n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy4); end
    n_cmp++; if (done4 !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done4); end
    n_cmp++; if (sel4 !== 2'd0) begin n_err++; $display("FAIL reset_sel got %0d exp 0", sel4); end
    reset_n = 1'b1;
    step();
    n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL rel_busy got %b exp 0", busy4); end
    n_cmp++; if (an4 !== 4'b1110) begin n_err++; $display("FAIL rel_an4 got %b exp 1110", an4); end
    n_cmp++; if (an1 !== an_exp(4'b1110, int'(cnt % 4)))
      begin n_err++; $display("FAIL rel_an1 got %b exp %b", an1, an_exp(4'b1110, int'(cnt % 4))); end
  endtask

  task automatic test_convert_scan();
    int s;
    for (int i = 0; i < 16; i++) begin
      load = (i == 0); bin_in = 13'd1234;
      step();
      n_cmp++; if (busy4 !== (i <= 13))
        begin n_err++; $display("FAIL conv_busy i=%0d got %b exp %b", i, busy4, (i <= 13)); end
      n_cmp++; if (done4 !== (i == 14))
        begin n_err++; $display("FAIL conv_done i=%0d got %b exp %b", i, done4, (i == 14)); end
    end
    load = 1'b0;
    for (int j = 0; j < 16; j++) begin
      s = int'((cnt / 4) % 4);
      n_cmp++; if (sel4 !== 2'(s))
        begin n_err++; $display("FAIL scan_sel got %0d exp %0d", sel4, s); end
      n_cmp++; if (an4 !== an_exp(4'b0000, s))
        begin n_err++; $display("FAIL scan_an got %b exp %b", an4, an_exp(4'b0000, s)); end
      n_cmp++; if (bcd4 !== dig(16'h1234, s))
        begin n_err++; $display("FAIL scan_bcd got %0d exp %0d", bcd4, dig(16'h1234, s)); end
      step();
    end
  endtask

  task automatic run_conv(input logic [12:0] v);
    int k;
    bin_in = v; load = 1'b1;
    step();
    load = 1'b0;
    k = 0;
    while (!done1 && k < 20) begin step(); k++; end
    n_cmp++; if (done1 !== 1'b1)
      begin n_err++; $display("FAIL conv_timeout value=%0d got done=%b exp 1", v, done1); end
  endtask

  task automatic test_blanking();
    logic [12:0] vals [4];
    logic [15:0] bcds [4];
    logic [3:0]  blks [4];
    int s;
    vals = '{13'd7, 13'd0, 13'd8191, 13'd1005};
    bcds = '{16'h0007, 16'h0000, 16'h8191, 16'h1005};
    blks = '{4'b1110, 4'b1110, 4'b0000, 4'b0000};
    for (int t = 0; t < 4; t++) begin
      run_conv(vals[t]);
      for (int j = 0; j < 4; j++) begin
        step();
        s = int'(cnt % 4);
        n_cmp++; if (bcd1 !== dig(bcds[t], s))
          begin n_err++; $display("FAIL blank_bcd v=%0d slot=%0d got %0d exp %0d", vals[t], s, bcd1, dig(bcds[t], s)); end
        n_cmp++; if (an1 !== an_exp(blks[t], s))
          begin n_err++; $display("FAIL blank_an v=%0d slot=%0d got %b exp %b", vals[t], s, an1, an_exp(blks[t], s)); end
      end
    end
  endtask

  task automatic test_pending();
    int s;
    for (int i = 0; i < 32; i++) begin
      load = (i == 0) || (i == 5) || (i == 9);
      bin_in = (i == 0) ? 13'd100 : (i == 5) ? 13'd200 : 13'd300;
      step();
      n_cmp++; if (done1 !== ((i == 14) || (i == 28)))
        begin n_err++; $display("FAIL pend_done i=%0d got %b", i, done1); end
      n_cmp++; if (busy1 !== (i <= 27))
        begin n_err++; $display("FAIL pend_busy i=%0d got %b exp %b", i, busy1, (i <= 27)); end
      if (i >= 15 && i <= 18) begin
        s = int'(cnt % 4);
        n_cmp++; if (bcd1 !== dig(16'h0100, s) || an1 !== an_exp(4'b1000, s))
          begin n_err++; $display("FAIL pend_first slot=%0d got %0d/%b exp %0d/%b", s, bcd1, an1, dig(16'h0100, s), an_exp(4'b1000, s)); end
      end
    end
    load = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      s = int'(cnt % 4);
      n_cmp++; if (bcd1 !== dig(16'h0300, s) || an1 !== an_exp(4'b1000, s))
        begin n_err++; $display("FAIL pend_last slot=%0d got %0d/%b exp %0d/%b", s, bcd1, an1, dig(16'h0300, s), an_exp(4'b1000, s)); end
    end
  endtask

  task automatic test_reset_abort();
    int s;
    int dones;
    for (int i = 0; i < 7; i++) begin
      load = (i == 0); bin_in = 13'd4321;
      step();
    end
    load = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (busy1 !== 1'b0 || busy4 !== 1'b0)
      begin n_err++; $display("FAIL abort_busy got %b/%b exp 0/0", busy1, busy4); end
    n_cmp++; if (bcd1 !== 4'd0 || an1 !== 4'b1110)
      begin n_err++; $display("FAIL abort_out got %0d/%b exp 0/1110", bcd1, an1); end
    step(); step();
    reset_n = 1'b1;
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (done1 || done4) dones++;
      if (j < 4) begin
        s = int'(cnt % 4);
        n_cmp++; if (bcd1 !== 4'd0 || an1 !== an_exp(4'b1110, s))
          begin n_err++; $display("FAIL abort_digits slot=%0d got %0d/%b exp 0/%b", s, bcd1, an1, an_exp(4'b1110, s)); end
      end
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL abort_done got %0d ticks exp 0", dones); end
  endtask

  task automatic test_back_to_back();
    int s;
    for (int i = 0; i < 31; i++) begin
      load = (i == 0) || (i == 14);
      bin_in = (i == 0) ? 13'd56 : 13'd789;
      step();
      s = int'(cnt % 4);
      n_cmp++; if (sel1 !== 2'(s))
        begin n_err++; $display("FAIL b2b_sel i=%0d got %0d exp %0d", i, sel1, s); end
      n_cmp++; if (done1 !== ((i == 14) || (i == 28)))
        begin n_err++; $display("FAIL b2b_done i=%0d got %b", i, done1); end
      n_cmp++; if (busy1 !== (i <= 27))
        begin n_err++; $display("FAIL b2b_busy i=%0d got %b exp %b", i, busy1, (i <= 27)); end
      if (i >= 15 && i <= 18) begin
        n_cmp++; if (bcd1 !== dig(16'h0056, s) || an1 !== an_exp(4'b1100, s))
          begin n_err++; $display("FAIL b2b_first slot=%0d got %0d/%b exp %0d/%b", s, bcd1, an1, dig(16'h0056, s), an_exp(4'b1100, s)); end
      end
    end
    load = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      s = int'(cnt % 4);
      n_cmp++; if (bcd1 !== dig(16'h0789, s) || an1 !== an_exp(4'b1000, s))
        begin n_err++; $display("FAIL b2b_second slot=%0d got %0d/%b exp %0d/%b", s, bcd1, an1, dig(16'h0789, s), an_exp(4'b1000, s)); end
    end
  endtask

  initial begin
    test_reset();
    test_convert_scan();
    test_blanking();
    test_pending();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
